seq_pattern_tx: RTL and testbench



---
 rtl/seq_pattern_tx_if.sv | 33 +++
 rtl/seq_pattern_tx.sv | 110 +++++++++++
 tb/tb_seq_pattern_tx.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_pattern_tx_if.sv
// ============================================================================
// Module      : seq_pattern_tx_if
// Description : Control and serial-output bundle for seq_pattern_tx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_pattern_tx_if #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 4
);
    logic             load;
    logic [WIDTH-1:0] pat_in;
    logic             start;
    logic [CNT_W-1:0] reps;
    logic             abort;
    logic             out;
    logic             valid;
    logic             busy;
    logic             done;

    modport master (
        output load, pat_in, start, reps, abort,
        input  out, valid, busy, done
    );

    modport slave (
        input  load, pat_in, start, reps, abort,
        output out, valid, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/seq_pattern_tx.sv
// ============================================================================
// Module      : seq_pattern_tx
// Description : Moore FSM sending a stored pattern MSB-first, N times, with
//               an optional idle gap between repetitions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_pattern_tx #(
    parameter int               WIDTH   = 5,
    parameter logic [WIDTH-1:0] PATTERN = 5'b10110,
    parameter int               CNT_W   = 4,
    parameter int               GAP     = 0
) (
    input  wire logic        clk,
    input  wire logic        rst,
    seq_pattern_tx_if.slave  bus
);
    localparam int BW = $clog2(WIDTH);
    localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;

    localparam logic [BW-1:0]    C_LAST_BIT = BW'(WIDTH - 1);
    localparam logic [GW-1:0]    C_GAP      = GW'(GAP);
    localparam logic [CNT_W-1:0] C_ONE_REP  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_pattern;
    logic [WIDTH-1:0] r_shreg;
    logic [BW-1:0]    r_bit;
    logic [CNT_W-1:0] r_rep;
    logic [GW-1:0]    r_gap;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pattern <= PATTERN;
            r_shreg   <= '0;
            r_bit     <= '0;
            r_rep     <= '0;
            r_gap     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.load) begin
                        r_pattern <= bus.pat_in;
                    end
                    // A simultaneous load is transmitted immediately.
                    if (bus.start && (bus.reps != '0) && !bus.abort) begin
                        r_shreg <= bus.load ? bus.pat_in : r_pattern;
                        r_rep   <= bus.reps;
                        r_bit   <= '0;
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
                        r_bit   <= r_bit + BW'(1);
                        if (r_bit == C_LAST_BIT) begin
                            r_rep <= r_rep - CNT_W'(1);
                            if (r_rep == C_ONE_REP) begin
                                r_state <= S_DONE;
                            end else if (GAP == 0) begin
                                r_shreg <= r_pattern;
                                r_bit   <= '0;
                            end else begin
                                r_gap   <= C_GAP;
                                r_state <= S_GAP;
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                    end else if (r_gap == GW'(1)) begin
                        r_shreg <= r_pattern;
                        r_bit   <= '0;
                        r_state <= S_SEND;
                    end else begin
                        r_gap <= r_gap - GW'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.out   = (r_state == S_SEND) & r_shreg[WIDTH-1];
    assign bus.valid = (r_state == S_SEND);
    assign bus.busy  = (r_state != S_IDLE);
    assign bus.done  = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
// ============================================================================
// Module      : tb_seq_pattern_tx
// Description : Bench driving GAP=0 and GAP=2 instances in lockstep against a
//               per-cycle expected-output queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_pattern_tx;
    localparam int             WIDTH   = 5;
    localparam int             CNT_W   = 4;
    localparam logic [WIDTH-1:0] DEF_PAT = 5'b10110;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic             load, start, abort;
    logic [WIDTH-1:0] pat_in;
    logic [CNT_W-1:0] reps;

    seq_pattern_tx_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus0 ();
    seq_pattern_tx_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus2 ();

    assign bus0.load = load;  assign bus0.pat_in = pat_in; assign bus0.start = start;
    assign bus0.reps = reps;  assign bus0.abort  = abort;
    assign bus2.load = load;  assign bus2.pat_in = pat_in; assign bus2.start = start;
    assign bus2.reps = reps;  assign bus2.abort  = abort;

    seq_pattern_tx #(.WIDTH(WIDTH), .PATTERN(DEF_PAT), .CNT_W(CNT_W), .GAP(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave));
    seq_pattern_tx #(.WIDTH(WIDTH), .PATTERN(DEF_PAT), .CNT_W(CNT_W), .GAP(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2.slave));

    // Observed/expected vectors are {out, valid, busy, done}.
    logic [3:0] obs0, obs2, exp0, exp2;
    assign obs0 = {bus0.out, bus0.valid, bus0.busy, bus0.done};
    assign obs2 = {bus2.out, bus2.valid, bus2.busy, bus2.done};

    // Model: per DUT, a queue of the outputs for every remaining busy cycle.
    logic [3:0]       mq [2][$];
    logic [WIDTH-1:0] m_pat [2];
    int               m_gap [2] = '{0, 2};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic model_edge();
        logic [WIDTH-1:0] p;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                mq[d].delete();
                m_pat[d] = DEF_PAT;
            end else if (mq[d].size() != 0) begin
                if (abort) mq[d].delete();
                else void'(mq[d].pop_front());
            end else begin
                p = load ? pat_in : m_pat[d];
                if (load) m_pat[d] = pat_in;
                if (start && reps != 0 && !abort) begin
                    for (int r = 0; r < int'(reps); r++) begin
                        for (int i = WIDTH - 1; i >= 0; i--)
                            mq[d].push_back({p[i], 1'b1, 1'b1, 1'b0});
                        if (r < int'(reps) - 1)
                            for (int g = 0; g < m_gap[d]; g++) mq[d].push_back(4'b0010);
                    end
                    mq[d].push_back(4'b0011);
                end
            end
        end
        exp0 = (mq[0].size() != 0) ? mq[0][0] : 4'b0000;
        exp2 = (mq[1].size() != 0) ? mq[1][0] : 4'b0000;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic l, input logic [WIDTH-1:0] p, input logic s,
                         input logic [CNT_W-1:0] r, input logic a);
        load = l; pat_in = p; start = s; reps = r; abort = a;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, '0, 1'b1, 4'd3, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks += 2;
            if (obs0 !== 4'b0000 || obs0 !== exp0) begin
                n_fail++; $display("FAIL reset dut0 cyc=%0d got=%b exp=0000", c, obs0);
            end
            if (obs2 !== 4'b0000 || obs2 !== exp2) begin
                n_fail++; $display("FAIL reset dut2 cyc=%0d got=%b exp=0000", c, obs2);
            end
        end
        rst = 1'b0;
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        tick();
    endtask

    task automatic test_single();
        logic [WIDTH-1:0] seq = 5'b10110;
        drive(1'b0, '0, 1'b1, 4'd1, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        for (int i = 0; i < WIDTH; i++) begin
            n_checks += 2;
            if (bus0.out !== seq[WIDTH-1-i] || bus0.valid !== 1'b1) begin
                n_fail++; $display("FAIL single_bits bit=%0d got out=%b valid=%b exp out=%b valid=1",
                                   i, bus0.out, bus0.valid, seq[WIDTH-1-i]);
            end
            if (obs2 !== exp2) begin
                n_fail++; $display("FAIL single dut2 bit=%0d got=%b exp=%b", i, obs2, exp2);
            end
            tick();
        end
        n_checks++;
        if (obs0 !== 4'b0011) begin
            n_fail++; $display("FAIL single_done got=%b exp=0011", obs0);
        end
        tick();
        n_checks++;
        if (obs0 !== 4'b0000) begin
            n_fail++; $display("FAIL single_idle got=%b exp=0000", obs0);
        end
    endtask

    task automatic test_back_to_back();
        int nvalid = 0;
        drive(1'b0, '0, 1'b1, 4'd2, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        for (int c = 0; c < 60 && (mq[0].size() != 0 || mq[1].size() != 0); c++) begin
            n_checks += 2;
            if (obs0 !== exp0) begin
                n_fail++; $display("FAIL b2b dut0 cyc=%0d got=%b exp=%b", c, obs0, exp0);
            end
            if (obs2 !== exp2) begin
                n_fail++; $display("FAIL b2b dut2 cyc=%0d got=%b exp=%b", c, obs2, exp2);
            end
            if (c < 10 && bus0.valid === 1'b1) nvalid++;
            tick();
        end
        n_checks++;
        if (nvalid != 10) begin
            n_fail++; $display("FAIL b2b_contiguous got=%0d exp=10", nvalid);
        end
    endtask

    task automatic test_gap();
        int nbusy = 0;
        drive(1'b0, '0, 1'b1, 4'd3, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        for (int c = 0; c < 60 && (mq[0].size() != 0 || mq[1].size() != 0); c++) begin
            n_checks += 2;
            if (obs0 !== exp0) begin
                n_fail++; $display("FAIL gap dut0 cyc=%0d got=%b exp=%b", c, obs0, exp0);
            end
            if (obs2 !== exp2) begin
                n_fail++; $display("FAIL gap dut2 cyc=%0d got=%b exp=%b", c, obs2, exp2);
            end
            if (bus2.busy === 1'b1 && bus2.done !== 1'b1) nbusy++;
            tick();
        end
        n_checks++;
        if (nbusy != 19) begin
            n_fail++; $display("FAIL gap_busy_before_done got=%0d exp=19", nbusy);
        end
    endtask

    task automatic test_load_start();
        logic [WIDTH-1:0] seq = 5'b01101;
        for (int pass = 0; pass < 2; pass++) begin
            drive(pass == 0, seq, 1'b1, 4'd1, 1'b0);
            tick();
            drive(1'b0, '0, 1'b0, '0, 1'b0);
            for (int i = 0; i < WIDTH; i++) begin
                n_checks += 2;
                if (bus0.out !== seq[WIDTH-1-i] || bus0.valid !== 1'b1) begin
                    n_fail++; $display("FAIL load_bits pass=%0d bit=%0d got=%b exp=%b",
                                       pass, i, bus0.out, seq[WIDTH-1-i]);
                end
                if (obs2 !== exp2) begin
                    n_fail++; $display("FAIL load dut2 bit=%0d got=%b exp=%b", i, obs2, exp2);
                end
                tick();
            end
            tick();
        end
    endtask

    task automatic test_abort();
        drive(1'b0, '0, 1'b1, 4'd4, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        tick(); tick();
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        tick();
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            n_checks += 2;
            if (obs0 !== 4'b0000 || obs0 !== exp0) begin
                n_fail++; $display("FAIL abort dut0 cyc=%0d got=%b exp=0000", c, obs0);
            end
            if (obs2 !== 4'b0000 || obs2 !== exp2) begin
                n_fail++; $display("FAIL abort dut2 cyc=%0d got=%b exp=0000", c, obs2);
            end
            tick();
        end
        drive(1'b0, '0, 1'b1, 4'd1, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        for (int c = 0; c < 60 && (mq[0].size() != 0 || mq[1].size() != 0); c++) begin
            n_checks += 2;
            if (obs0 !== exp0) begin
                n_fail++; $display("FAIL abort_restart dut0 cyc=%0d got=%b exp=%b", c, obs0, exp0);
            end
            if (obs2 !== exp2) begin
                n_fail++; $display("FAIL abort_restart dut2 cyc=%0d got=%b exp=%b", c, obs2, exp2);
            end
            tick();
        end
    endtask

    task automatic test_ignore();
        drive(1'b0, '0, 1'b1, 4'd0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        n_checks++;
        if (obs0 !== 4'b0000) begin
            n_fail++; $display("FAIL reps0 got=%b exp=0000", obs0);
        end
        drive(1'b0, '0, 1'b1, 4'd2, 1'b0);
        tick();
        for (int c = 0; c < 60 && (mq[0].size() != 0 || mq[1].size() != 0); c++) begin
            drive(c < 8, 5'b11111, c < 8, 4'd5, 1'b0);
            n_checks += 2;
            if (obs0 !== exp0) begin
                n_fail++; $display("FAIL busy_ignore dut0 cyc=%0d got=%b exp=%b", c, obs0, exp0);
            end
            if (obs2 !== exp2) begin
                n_fail++; $display("FAIL busy_ignore dut2 cyc=%0d got=%b exp=%b", c, obs2, exp2);
            end
            tick();
        end
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        tick();
        n_checks++;
        if (dut0.r_pattern !== 5'b01101) begin
            n_fail++; $display("FAIL pattern_kept got=%b exp=01101", dut0.r_pattern);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            drive($urandom_range(0, 3) == 0, WIDTH'($urandom), $urandom_range(0, 3) == 0,
                  ($urandom_range(0, 7) == 0) ? CNT_W'($urandom_range(0, 15))
                                              : CNT_W'($urandom_range(0, 3)),
                  $urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 149) == 0);
            tick();
            n_checks += 2;
            if (obs0 !== exp0) begin
                n_fail++; $display("FAIL random dut0 cyc=%0d got=%b exp=%b", c, obs0, exp0);
            end
            if (obs2 !== exp2) begin
                n_fail++; $display("FAIL random dut2 cyc=%0d got=%b exp=%b", c, obs2, exp2);
            end
        end
        rst = 1'b0;
        drive(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        test_reset();
        test_single();
        test_back_to_back();
        test_gap();
        test_load_start();
        test_abort();
        test_ignore();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
